// File: rtl/adc_serial_capture.sv
// ---------------------------------------------------------------------------
// adc_serial_capture
//
// Serial ADC front end for the oscilloscope datapath. It generates the ADC
// serial clock and convert strobe and deserialises one MSB-first frame per
// conversion. It keeps the OUT_BITS most significant bits of each frame and
// presents them through a one-entry valid/ready holding register. The
// holding register also carries a level-crossing trigger flag and a sticky
// overrun indication.
//
// Ports
//   osc_clk       system clock, rising edge
//   reset         asynchronous reset, active low
//   enable        run continuous conversions
//   adc_data      serial data from the ADC
//   adc_clk       ADC serial clock (divider MSB)
//   adc_conv      ADC convert / chip select, high between frames
//   sample_data   captured sample (top OUT_BITS of the frame)
//   sample_trig   trigger sideband, qualified by sample_valid
//   sample_valid  holding register full
//   sample_ready  consumer accepts when valid & ready
//   trig_level    unsigned trigger threshold
//   trig_rise     1 = rising-crossing trigger, 0 = falling-crossing trigger
//   clr_overrun   clears overrun
//   overrun       sticky: a sample was dropped
// ---------------------------------------------------------------------------
module adc_serial_capture #(
  parameter int DIV_LOG2  = 5,
  parameter int ADC_BITS  = 12,
  parameter int LEAD_BITS = 1,
  parameter int OUT_BITS  = 8,
  parameter int CONV_HIGH = 1
) (
  input  logic                osc_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_data,
  output logic                adc_clk,
  output logic                adc_conv,
  output logic [OUT_BITS-1:0] sample_data,
  output logic                sample_trig,
  output logic                sample_valid,
  input  logic                sample_ready,
  input  logic [OUT_BITS-1:0] trig_level,
  input  logic                trig_rise,
  input  logic                clr_overrun,
  output logic                overrun
);

  localparam int LEAD_TICKS = 1 + LEAD_BITS;
  localparam int MAX_A      = (CONV_HIGH > LEAD_TICKS) ? CONV_HIGH : LEAD_TICKS;
  localparam int MAX_CNT    = (MAX_A > ADC_BITS) ? MAX_A : ADC_BITS;
  localparam int CNT_W      = $clog2(MAX_CNT + 1);

  // Divider value on the edge where adc_clk is about to rise.
  localparam logic [DIV_LOG2-1:0] TICK_AT = DIV_LOG2'((1 << (DIV_LOG2 - 1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_LEAD,
    S_SHIFT,
    S_DONE
  } state_t;

  logic [DIV_LOG2-1:0] div_q, div_d;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADC_BITS-1:0] sr_q, sr_d;
  logic                adc_conv_q, adc_conv_d;
  logic [OUT_BITS-1:0] sample_data_q, sample_data_d;
  logic                sample_trig_q, sample_trig_d;
  logic                sample_valid_q, sample_valid_d;
  logic                overrun_q, overrun_d;
  logic                prev_valid_q, prev_valid_d;

  logic                tick;
  logic [OUT_BITS-1:0] new_sample;
  logic                trig_hit;

  // Level-crossing test between the previously delivered sample and the new one.
  function automatic logic crossed(input logic [OUT_BITS-1:0] prev,
                                   input logic [OUT_BITS-1:0] cur,
                                   input logic [OUT_BITS-1:0] level,
                                   input logic                rise);
    if (rise) begin
      return (prev < level) && (cur >= level);
    end
    return (prev > level) && (cur <= level);
  endfunction

  // True on the tick that completes a phase lasting n ticks.
  function automatic logic last_tick(input logic [CNT_W-1:0] cnt, input int n);
    return cnt == CNT_W'(n - 1);
  endfunction

  assign tick       = (div_q == TICK_AT);
  assign new_sample = sr_q[ADC_BITS-1 -: OUT_BITS];
  // The holding register always contains the last loaded sample, so it
  // doubles as the "previous sample" for the trigger.
  assign trig_hit   = prev_valid_q && crossed(sample_data_q, new_sample, trig_level, trig_rise);

  always_comb begin
    div_d          = div_q + DIV_LOG2'(1);
    state_d        = state_q;
    cnt_d          = cnt_q;
    sr_d           = sr_q;
    sample_data_d  = sample_data_q;
    sample_trig_d  = sample_trig_q;
    prev_valid_d   = prev_valid_q;
    // Consumer handshake; a load in DONE below takes precedence.
    sample_valid_d = sample_valid_q & ~sample_ready;
    // Clear first so a drop in the same cycle wins.
    overrun_d      = overrun_q & ~clr_overrun;

    case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          state_d      = S_CONV;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
        end
      end
      S_CONV: begin
        if (tick) begin
          if (last_tick(cnt_q, CONV_HIGH)) begin
            state_d = S_LEAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LEAD: begin
        if (tick) begin
          if (last_tick(cnt_q, LEAD_TICKS)) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_SHIFT: begin
        if (tick) begin
          sr_d = (sr_q << 1) | ADC_BITS'(adc_data);
          if (last_tick(cnt_q, ADC_BITS)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = enable ? S_CONV : S_IDLE;
        cnt_d   = '0;
        if (!sample_valid_q || sample_ready) begin
          sample_data_d  = new_sample;
          sample_trig_d  = trig_hit;
          sample_valid_d = 1'b1;
          prev_valid_d   = 1'b1;
        end else begin
          // Holding register still owned by the consumer: drop this sample.
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Convert strobe is low only while the frame is being clocked out.
    adc_conv_d = !((state_d == S_LEAD) || (state_d == S_SHIFT));
  end

  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      div_q          <= '0;
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      adc_conv_q     <= 1'b1;
      sample_data_q  <= '0;
      sample_trig_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      prev_valid_q   <= 1'b0;
    end else begin
      div_q          <= div_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      adc_conv_q     <= adc_conv_d;
      sample_data_q  <= sample_data_d;
      sample_trig_q  <= sample_trig_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      prev_valid_q   <= prev_valid_d;
    end
  end

  // Shift register is pure data; every frame refills it before it is read.
  always_ff @(posedge osc_clk) begin
    sr_q <= sr_d;
  end

  assign adc_clk      = div_q[DIV_LOG2-1];
  assign adc_conv     = adc_conv_q;
  assign sample_data  = sample_data_q;
  assign sample_trig  = sample_trig_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_capture
//
// Directed bench for adc_serial_capture. Two instances share clock and reset:
// u_dut uses DIV_LOG2=2 with default frame parameters, and u_dut2 uses
// DIV_LOG2=2, OUT_BITS=12, LEAD_BITS=0, CONV_HIGH=3. A small behavioural ADC
// per instance shifts a queued 12-bit word out on falling adc_clk once
// adc_conv falls, after the lead (junk) periods.
// ---------------------------------------------------------------------------
module tb_adc_serial_capture;

  logic osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  logic        reset;
  // instance 1
  logic        enable, adc_clk, adc_conv;
  logic        adc_data = 1'b0;
  logic [7:0]  sample_data, trig_level;
  logic        sample_trig, sample_valid, sample_ready, trig_rise, clr_overrun, overrun;
  // instance 2
  logic        enable2, adc_clk2, adc_conv2;
  logic        adc_data2 = 1'b0;
  logic [11:0] sample_data2, trig_level2;
  logic        sample_trig2, sample_valid2, sample_ready2, trig_rise2, clr_overrun2, overrun2;

  adc_serial_capture #(.DIV_LOG2(2)) u_dut (
    .osc_clk(osc_clk), .reset(reset), .enable(enable), .adc_data(adc_data),
    .adc_clk(adc_clk), .adc_conv(adc_conv), .sample_data(sample_data),
    .sample_trig(sample_trig), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .trig_level(trig_level), .trig_rise(trig_rise), .clr_overrun(clr_overrun),
    .overrun(overrun)
  );

  adc_serial_capture #(.DIV_LOG2(2), .ADC_BITS(12), .LEAD_BITS(0), .OUT_BITS(12),
                       .CONV_HIGH(3)) u_dut2 (
    .osc_clk(osc_clk), .reset(reset), .enable(enable2), .adc_data(adc_data2),
    .adc_clk(adc_clk2), .adc_conv(adc_conv2), .sample_data(sample_data2),
    .sample_trig(sample_trig2), .sample_valid(sample_valid2), .sample_ready(sample_ready2),
    .trig_level(trig_level2), .trig_rise(trig_rise2), .clr_overrun(clr_overrun2),
    .overrun(overrun2)
  );

  // ---------------- behavioural ADCs ----------------
  logic [11:0] word_q1[$];
  logic [11:0] word_q2[$];
  logic [11:0] cur1 = '0, cur2 = '0;
  int          bit1 = 0, bit2 = 0, idx1 = 0, idx2 = 0;

  always @(negedge adc_conv) begin
    if (word_q1.size() > 0) cur1 = word_q1.pop_front();
    else cur1 = '0;
    bit1 = 0;
  end

  // Junk for 1+LEAD_BITS periods, MSB appears at the (LEAD_BITS+2)th fall.
  always @(negedge adc_clk) begin
    if (adc_conv === 1'b0) begin
      bit1 = bit1 + 1;
      idx1 = bit1 - 3;
      adc_data = (idx1 >= 0 && idx1 < 12) ? cur1[11-idx1] : 1'b1;
    end
  end

  always @(negedge adc_conv2) begin
    if (word_q2.size() > 0) cur2 = word_q2.pop_front();
    else cur2 = '0;
    bit2 = 0;
  end

  always @(negedge adc_clk2) begin
    if (adc_conv2 === 1'b0) begin
      bit2 = bit2 + 1;
      idx2 = bit2 - 2;
      adc_data2 = (idx2 >= 0 && idx2 < 12) ? cur2[11-idx2] : 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges (sampling #1 after each) until the selected
  // condition holds; an expired budget is recorded as a failed check.
  task automatic wait_for(input int sel, input int budget, input string tag, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge osc_clk);
      #1;
      n++;
      case (sel)
        0:       hit = (sample_valid === 1'b1);
        1:       hit = (sample_valid2 === 1'b1);
        2:       hit = (overrun === 1'b1);
        3:       hit = (adc_conv2 === 1'b1);
        4:       hit = (adc_conv2 === 1'b0);
        default: hit = 1'b1;
      endcase
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge osc_clk);
    reset = 1'b0;
    word_q1.delete();
    word_q2.delete();
    repeat (2) @(negedge osc_clk);
  endtask

  task automatic release_reset();
    @(negedge osc_clk);
    reset = 1'b1;
  endtask

  logic [7:0] c_data [5] = '{8'h40, 8'h90, 8'hA0, 8'h90, 8'h80};
  logic       c_trig [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    int hc;
    int vcount;
    int convlow;

    reset         = 1'b0;
    enable        = 1'b0;
    sample_ready  = 1'b1;
    trig_level    = 8'h80;
    trig_rise     = 1'b1;
    clr_overrun   = 1'b0;
    enable2       = 1'b0;
    sample_ready2 = 1'b1;
    trig_level2   = 12'h800;
    trig_rise2    = 1'b1;
    clr_overrun2  = 1'b0;

    // Reset state
    repeat (3) @(posedge osc_clk);
    #1;
    check("rst_conv", adc_conv, 1);
    check("rst_clk", adc_clk, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_data", sample_data, 0);
    check("rst_trig", sample_trig, 0);

    // Basic capture, first-sample latency, one-cycle valid, frame spacing
    enable = 1'b1;
    word_q1.push_back(12'hA5C);
    word_q1.push_back(12'hB27);
    release_reset();
    wait_for(0, 200, "a_first", n);
    check("a_latency", n, 63);
    check("a_data", sample_data, 8'hA5);
    check("a_trig", sample_trig, 0);
    @(posedge osc_clk);
    #1;
    check("a_pulse", sample_valid, 0);
    wait_for(0, 200, "a_second", n);
    check("a_spacing", n + 1, 60);
    check("a_data2", sample_data, 8'hB2);
    check("a_trig2", sample_trig, 0);

    // Overrun with a stalled consumer
    do_reset();
    sample_ready = 1'b0;
    word_q1.push_back(12'h123);
    word_q1.push_back(12'h345);
    release_reset();
    wait_for(0, 200, "b_first", n);
    check("b_data1", sample_data, 8'h12);
    wait_for(2, 200, "b_ovr", n);
    check("b_ovr_gap", n, 60);
    check("b_hold_data", sample_data, 8'h12);
    check("b_hold_valid", sample_valid, 1);
    check("b_ovr", overrun, 1);
    clr_overrun = 1'b1;
    @(posedge osc_clk);
    #1;
    clr_overrun = 1'b0;
    check("b_ovr_clr", overrun, 0);
    sample_ready = 1'b1;
    @(posedge osc_clk);
    #1;
    sample_ready = 1'b0;
    check("b_consume", sample_valid, 0);
    check("b_data_kept", sample_data, 8'h12);
    // Next frame loads; the one after is dropped in the same cycle as a clear.
    wait_for(0, 200, "b_third", n);
    check("b_third_gap", n, 58);
    repeat (59) @(posedge osc_clk);
    #1;
    clr_overrun = 1'b1;
    @(posedge osc_clk);
    #1;
    clr_overrun = 1'b0;
    check("b_setclr", overrun, 1);

    // Trigger: rising then falling crossings around 0x80
    do_reset();
    sample_ready = 1'b1;
    trig_rise    = 1'b1;
    word_q1.push_back(12'h405);
    word_q1.push_back(12'h90A);
    word_q1.push_back(12'hA0F);
    word_q1.push_back(12'h903);
    word_q1.push_back(12'h806);
    release_reset();
    for (int i = 0; i < 5; i++) begin
      wait_for(0, 200, $sformatf("c_wait%0d", i), n);
      check($sformatf("c_data%0d", i), sample_data, c_data[i]);
      check($sformatf("c_trig%0d", i), sample_trig, c_trig[i]);
      if (i == 2) trig_rise = 1'b0;
    end

    // Drop enable mid-SHIFT: frame completes, then nothing more
    word_q1.push_back(12'h7E5);
    repeat (20) @(posedge osc_clk);
    #1;
    check("d_in_frame", adc_conv, 0);
    enable = 1'b0;
    wait_for(0, 100, "d_last", n);
    check("d_data", sample_data, 8'h7E);
    vcount  = 0;
    convlow = 0;
    repeat (200) begin
      @(posedge osc_clk);
      #1;
      if (sample_valid !== 1'b0) vcount++;
      if (adc_conv !== 1'b1) convlow++;
    end
    check("d_no_more", vcount, 0);
    check("d_conv_high", convlow, 0);
    // Re-enable: 0x7E -> 0xC3 would be a rising crossing, but prev is cleared
    trig_rise = 1'b1;
    word_q1.push_back(12'hC31);
    enable = 1'b1;
    wait_for(0, 200, "d_reen", n);
    check("d_reen_data", sample_data, 8'hC3);
    check("d_reen_trig", sample_trig, 0);

    // Asynchronous reset in the middle of SHIFT
    do_reset();
    word_q1.push_back(12'hFFF);
    release_reset();
    repeat (30) @(posedge osc_clk);
    #1;
    check("e_pre_conv", adc_conv, 0);
    #2;
    reset = 1'b0;
    #1;
    check("e_conv", adc_conv, 1);
    check("e_clk", adc_clk, 0);
    check("e_clk2", adc_clk2, 0);
    check("e_valid", sample_valid, 0);
    check("e_ovr", overrun, 0);
    word_q1.delete();
    word_q1.push_back(12'h5A0);
    release_reset();
    wait_for(0, 200, "e_after", n);
    check("e_latency", n, 63);
    check("e_data", sample_data, 8'h5A);

    // Full-width instance: 12-bit samples, no lead bits, 3-tick convert
    do_reset();
    enable2 = 1'b1;
    word_q2.push_back(12'hABC);
    word_q2.push_back(12'h123);
    release_reset();
    wait_for(1, 200, "f_first", n);
    check("f_latency", n, 67);
    check("f_data", sample_data2, 12'hABC);
    check("f_trig", sample_trig2, 0);
    wait_for(1, 200, "f_second", n);
    check("f_spacing", n, 64);
    check("f_data2", sample_data2, 12'h123);
    check("f_ovr", overrun2, 0);
    wait_for(4, 200, "f_conv_fall", n);
    wait_for(3, 200, "f_conv_rise", n);
    hc = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge osc_clk);
      #1;
      if (adc_conv2 !== 1'b1) break;
      hc++;
    end
    check("f_conv_high", hc, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
Parametrised next-generation serial ADC front end for the oscilloscope datapath. It generates adc_clk and adc_conv, deserialises one MSB-first frame per conversion, and keeps the OUT_BITS most significant data bits. Each sample is delivered over a valid/ready handshake with a one-entry holding register, overrun detection and a level-crossing trigger flag, so the downstream memory block can stall and arm acquisition on a trigger.

Parameters:
DIV_LOG2, 5, adc_clk period = 2^DIV_LOG2 osc_clk cycles (minimum 2)
ADC_BITS, 12, data bits per frame
LEAD_BITS, 1, junk adc_clk periods after conv falls before MSB (minimum 0)
OUT_BITS, 8, kept MSBs; 1 <= OUT_BITS <= ADC_BITS
CONV_HIGH, 1, adc_clk periods adc_conv held high between frames (minimum 1)

Ports:
osc_clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
enable  in  1  run continuous conversions
adc_data  in  1  serial data from ADC
adc_clk  out  1  ADC serial clock
adc_conv  out  1  ADC convert/chip-select, high between frames
sample_data  out  OUT_BITS  captured sample = frame bits [ADC_BITS-1 -: OUT_BITS]
sample_trig  out  1  trigger sideband, qualified by sample_valid
sample_valid  out  1  holding register full
sample_ready  in  1  consumer accepts when valid & ready
trig_level  in  OUT_BITS  trigger threshold, unsigned
trig_rise  in  1  1 = rising-crossing trigger, 0 = falling-crossing trigger
clr_overrun  in  1  clears overrun
overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset (reset=0, asynchronous): divider=0, adc_clk=0, adc_conv=1, state=IDLE, sample_valid=0, sample_data=0, sample_trig=0, overrun=0, prev_valid=0.
- Divider: free-running DIV_LOG2-bit counter; adc_clk = counter MSB. tick = counter == 2^(DIV_LOG2-1)-1, i.e. the osc_clk edge on which adc_clk rises. All FSM transitions and adc_data sampling occur on tick edges only. adc_clk runs in every state.
- FSM states:
  - IDLE: adc_conv=1. On tick with enable=1 -> CONV.
  - CONV: adc_conv=1 for CONV_HIGH ticks, then -> LEAD.
  - LEAD: adc_conv=0 for 1+LEAD_BITS ticks, no sampling, then -> SHIFT.
  - SHIFT: adc_conv=0. ADC_BITS ticks; each tick shifts adc_data into an ADC_BITS shift register MSB first. On the last tick -> DONE.
  - DONE: one osc_clk cycle. Loads the sample, then -> CONV if enable=1, else -> IDLE.
- Frame length = CONV_HIGH+1+LEAD_BITS+ADC_BITS ticks (defaults: 15).
- enable is sampled only in IDLE and DONE. Deasserting enable mid-frame lets the frame complete and deliver its sample.
- Delivery (in DONE):
  - If sample_valid=0, or valid&ready in the same cycle: sample_data <= new sample, sample_trig <= trigger result, sample_valid <= 1.
  - Otherwise the new sample is dropped, the holding register is unchanged, and overrun <= 1.
- Handshake: sample_valid clears on the cycle after valid&ready, unless DONE reloads it in that same cycle.
- Overrun: clr_overrun=1 clears overrun. A simultaneous set and clear leaves overrun=1.
- Trigger: prev = last sample loaded into the holding register.
  - Rising (trig_rise=1): prev < level and new >= level.
  - Falling (trig_rise=0): prev > level and new <= level.
  - Requires prev_valid=1. prev_valid clears on reset and on the IDLE->CONV transition, and sets on each load.
  - Dropped samples update neither prev nor the trigger.
- Reset mid-frame aborts immediately. No partial sample is emitted, and the next frame starts from IDLE.

Test Plan:
- reset=0 at any point, including mid-SHIFT -> adc_conv=1, adc_clk=0, sample_valid=0, overrun=0 within the same cycle. After release with enable=1 -> the first tick enters CONV.
- DIV_LOG2=2, defaults, enable=1, sample_ready=1; after the lead tick drive 0xA5C MSB-first on ticks -> sample_data=0xA5, one-cycle sample_valid. Frame-to-frame spacing = 60 osc_clk cycles.
- sample_ready=0; frames 0x12_, then 0x34_ -> sample_data stays 0x12, sample_valid=1, overrun=1. clr_overrun pulse -> overrun=0. Raise ready -> 0x12 consumed.
- trig_level=0x80, trig_rise=1; samples 0x40, 0x90, 0xA0 -> sample_trig 0,1,0. With trig_rise=0, samples 0x90, 0x80 -> sample_trig 0,1. The first sample after enable always has sample_trig=0.
- Drop enable during SHIFT -> the frame completes, its sample is delivered, adc_conv stays 1 and no further samples arrive. Re-enable -> a new frame starts with prev_valid cleared.
- OUT_BITS=12, LEAD_BITS=0, CONV_HIGH=3 -> full 12-bit sample returned, adc_conv high for 3 ticks, frame = 16 ticks.
